// File: rtl/bomb_pkg.sv
// bomb_pkg: shared types and constants for the bomb defuse controller.
//   state_t              - controller FSM states
//   CODE_DIGITS          - number of BCD digits in the secret code
//   DIGIT_W / CODE_W     - width of one digit / the packed code
//   MAX_ATTEMPTS_DEFAULT - default wrong-code count that locks entry
//   is_bcd()             - true when a 4-bit value is a decimal digit
package bomb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUNNING,
      S_LOCKED,
      S_DEFUSED,
      S_EXPLODED
   } state_t;

   localparam int CODE_DIGITS          = 4;
   localparam int DIGIT_W              = 4;
   localparam int CODE_W               = CODE_DIGITS * DIGIT_W;
   localparam int MAX_ATTEMPTS_DEFAULT = 3;

   function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
      return d <= DIGIT_W'(9);
   endfunction

endpackage

// File: rtl/code_entry_buffer.sv
// code_entry_buffer: shift register for entered code digits.
//   Clock, Reset      - clock and synchronous active-high reset
//   clear             - empty the buffer (wins over push)
//   push, digit       - append one BCD digit on the low end
//   count             - digits currently buffered (0..CODE_DIGITS)
//   last_digit        - the next push completes the code
//   code_match        - buffered digits plus 'digit' equal CODE
module code_entry_buffer
   import bomb_pkg::*;
#(
   parameter logic [CODE_W-1:0] CODE = 16'h1234
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               clear,
   input  logic               push,
   input  logic [DIGIT_W-1:0] digit,
   output logic [2:0]         count,
   output logic               last_digit,
   output logic               code_match
);

   logic [CODE_W-1:0] shift;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge Clock) begin
      if (Reset || clear) begin
         shift <= '0;
         count <= '0;
      end else if (push) begin
         shift <= {shift[CODE_W-DIGIT_W-1:0], digit};
         count <= count + 3'd1;
      end
   end

   // Compare against the value the shift register is about to hold, so the
   // FSM can decide on the same edge that accepts the final digit.
   assign last_digit = (count == 3'(CODE_DIGITS - 1));
   assign code_match = ({shift[CODE_W-DIGIT_W-1:0], digit} == CODE);

endmodule

// File: rtl/bomb_defuse_controller.sv
// bomb_defuse_controller: arms a bomb, collects a 4-digit BCD code and
// reports whether the bomb was defused or exploded.
//   Clock, Reset    - clock and synchronous active-high reset
//   Arm             - one-cycle request to (re)start a run
//   Digit_Valid     - qualifies Digit for one cycle
//   Digit           - entered BCD digit (values above 9 are ignored)
//   Counter_In      - bomb countdown value (informational only)
//   Blow_Up_In      - bomb explosion flag
//   Start, Stop     - level commands to the bomb
//   Bomb_Reset      - one-cycle reset pulse to the bomb
//   Defused         - code accepted, bomb stopped
//   Exploded        - bomb went off
//   Digits_Entered  - digits buffered for the current attempt
//   Wrong_Attempts  - failed codes since the last arm
module bomb_defuse_controller
   import bomb_pkg::*;
#(
   parameter logic [CODE_W-1:0] CODE         = 16'h1234,
   parameter int                MAX_ATTEMPTS = MAX_ATTEMPTS_DEFAULT
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Arm,
   input  logic               Digit_Valid,
   input  logic [DIGIT_W-1:0] Digit,
   input  logic [4:0]         Counter_In,
   input  logic               Blow_Up_In,
   output logic               Start,
   output logic               Stop,
   output logic               Bomb_Reset,
   output logic               Defused,
   output logic               Exploded,
   output logic [2:0]         Digits_Entered,
   output logic [1:0]         Wrong_Attempts
);

   localparam logic [1:0] MAX_W = MAX_ATTEMPTS[1:0];

   state_t     state;
   logic       arm_accept;
   logic       push;
   logic       last_digit;
   logic       code_match;
   logic       mismatch;
   logic       buf_clear;
   logic [1:0] next_wrong;

   // The countdown value never affects the controller; only Blow_Up_In
   // ends a run.
   logic unused_counter;
   assign unused_counter = ^Counter_In;

   // Arm restarts only from rest states; a run in progress ignores it.
   assign arm_accept = Arm && (state == S_IDLE || state == S_DEFUSED ||
                               state == S_EXPLODED);

   // An explosion in the same cycle suppresses the digit entirely.
   assign push       = (state == S_RUNNING) && Digit_Valid && is_bcd(Digit) &&
                       !Blow_Up_In;
   assign mismatch   = push && last_digit && !code_match;
   assign buf_clear  = arm_accept || (state == S_CLEAR) || mismatch;
   assign next_wrong = Wrong_Attempts + 2'd1;

   code_entry_buffer #(
      .CODE (CODE)
   ) u_buffer (
      .Clock      (Clock),
      .Reset      (Reset),
      .clear      (buf_clear),
      .push       (push),
      .digit      (Digit),
      .count      (Digits_Entered),
      .last_digit (last_digit),
      .code_match (code_match)
   );

   // NOTE: reset is checked first inside the clocked block, so it overrides
   // every other input on the same edge, even mid-run.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state          <= S_IDLE;
         Start          <= 1'b0;
         Stop           <= 1'b0;
         Bomb_Reset     <= 1'b0;
         Defused        <= 1'b0;
         Exploded       <= 1'b0;
         Wrong_Attempts <= 2'd0;
      end else begin
         case (state)
            S_IDLE, S_DEFUSED, S_EXPLODED: begin
               if (arm_accept) begin
                  state          <= S_CLEAR;
                  Start          <= 1'b0;
                  Stop           <= 1'b0;
                  Bomb_Reset     <= 1'b1;
                  Defused        <= 1'b0;
                  Exploded       <= 1'b0;
                  Wrong_Attempts <= 2'd0;
               end
            end

            S_CLEAR: begin
               state          <= S_RUNNING;
               Start          <= 1'b1;
               Stop           <= 1'b0;
               Bomb_Reset     <= 1'b0;
               Wrong_Attempts <= 2'd0;
            end

            S_RUNNING: begin
               if (Blow_Up_In) begin
                  state    <= S_EXPLODED;
                  Start    <= 1'b0;
                  Stop     <= 1'b0;
                  Exploded <= 1'b1;
               end else if (push && last_digit) begin
                  if (code_match) begin
                     state   <= S_DEFUSED;
                     Stop    <= 1'b1;
                     Defused <= 1'b1;
                  end else begin
                     Wrong_Attempts <= next_wrong;
                     if (next_wrong == MAX_W) begin
                        state <= S_LOCKED;
                     end
                  end
               end
            end

            S_LOCKED: begin
               if (Blow_Up_In) begin
                  state    <= S_EXPLODED;
                  Start    <= 1'b0;
                  Stop     <= 1'b0;
                  Exploded <= 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
               Start <= 1'b0;
               Stop  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bomb_defuse_controller.sv
// tb_bomb_defuse_controller: table-driven bench with a scoreboard queue.
// Each vector holds the inputs for one clock edge and the outputs expected
// right after that edge, packed as
// {Start, Stop, Bomb_Reset, Defused, Exploded, Digits_Entered, Wrong_Attempts}.
module tb_bomb_defuse_controller;

   typedef struct {
      string      name;
      logic       rst;
      logic       arm;
      logic       dv;
      logic [3:0] dig;
      logic       blow;
      logic [4:0] cin;
      logic [9:0] exp;
   } vec_t;

   typedef struct {
      string      name;
      logic [9:0] exp;
   } sb_t;

   logic       clock;
   logic       reset;
   logic       arm;
   logic       digit_valid;
   logic [3:0] digit;
   logic [4:0] counter_in;
   logic       blow_up_in;
   logic       start;
   logic       stop;
   logic       bomb_reset;
   logic       defused;
   logic       exploded;
   logic [2:0] digits_entered;
   logic [1:0] wrong_attempts;

   int checks   = 0;
   int failures = 0;

   vec_t tbl[$];
   sb_t  sb[$];

   bomb_defuse_controller #(
      .CODE         (16'h1234),
      .MAX_ATTEMPTS (3)
   ) dut (
      .Clock          (clock),
      .Reset          (reset),
      .Arm            (arm),
      .Digit_Valid    (digit_valid),
      .Digit          (digit),
      .Counter_In     (counter_in),
      .Blow_Up_In     (blow_up_in),
      .Start          (start),
      .Stop           (stop),
      .Bomb_Reset     (bomb_reset),
      .Defused        (defused),
      .Exploded       (exploded),
      .Digits_Entered (digits_entered),
      .Wrong_Attempts (wrong_attempts)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(string nm, bit rst, bit a, bit dv,
                               logic [3:0] dg, bit bl, logic [4:0] ci,
                               bit st, bit sp, bit br, bit df, bit ex,
                               int cnt, int wr);
      vec_t v;
      v.name = nm;
      v.rst  = rst;
      v.arm  = a;
      v.dv   = dv;
      v.dig  = dg;
      v.blow = bl;
      v.cin  = ci;
      v.exp  = {st, sp, br, df, ex, 3'(cnt), 2'(wr)};
      return v;
   endfunction

   // Plain digit entry, no other inputs.
   function automatic vec_t dk(string nm, logic [3:0] dg, bit st, bit sp,
                               bit df, int cnt, int wr);
      return mk(nm, 0, 0, 1, dg, 0, 5'd17, st, sp, 0, df, 0, cnt, wr);
   endfunction

   task automatic check(input string name, input logic [9:0] act,
                        input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b (st,sp,br,df,ex,cnt,wr)",
                  name, act, exp);
      end
   endtask

   // Drive one vector before the edge, queue its expectation, then compare
   // the registered outputs just after the edge.
   task automatic step(input vec_t v);
      sb_t e;
      sb_t got;
      @(negedge clock);
      reset       = v.rst;
      arm         = v.arm;
      digit_valid = v.dv;
      digit       = v.dig;
      blow_up_in  = v.blow;
      counter_in  = v.cin;
      e.name = v.name;
      e.exp  = v.exp;
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s scoreboard empty", v.name);
      end else begin
         got = sb.pop_front();
         check(got.name, {start, stop, bomb_reset, defused, exploded,
                          digits_entered, wrong_attempts}, got.exp);
      end
   endtask

   task automatic attempt(input string nm, input logic [3:0] last, input int wr_before,
                          input int wr_after);
      step(dk({nm, "_d1"}, 4'd1, 1, 0, 0, 1, wr_before));
      step(dk({nm, "_d2"}, 4'd2, 1, 0, 0, 2, wr_before));
      step(dk({nm, "_d3"}, 4'd3, 1, 0, 0, 3, wr_before));
      step(dk({nm, "_d4"}, last, 1, 0, 0, 0, wr_after));
   endtask

   initial begin
      reset = 1'b1; arm = 1'b0; digit_valid = 1'b0; digit = 4'd0;
      counter_in = 5'd20; blow_up_in = 1'b0;

      // Correct code, then re-arm from DEFUSED.
      tbl.push_back(mk("reset",          1,0,0,4'd0,0,5'd20, 0,0,0,0,0,0,0));
      tbl.push_back(mk("idle",           0,0,0,4'd0,0,5'd20, 0,0,0,0,0,0,0));
      tbl.push_back(mk("idle_dv_ignored",0,0,1,4'd1,0,5'd20, 0,0,0,0,0,0,0));
      tbl.push_back(mk("arm_clear",      0,1,0,4'd0,0,5'd20, 0,0,1,0,0,0,0));
      tbl.push_back(mk("running",        0,0,0,4'd0,0,5'd19, 1,0,0,0,0,0,0));
      tbl.push_back(dk("ok_d1", 4'd1, 1,0,0, 1,0));
      tbl.push_back(dk("ok_d2", 4'd2, 1,0,0, 2,0));
      tbl.push_back(dk("ok_d3", 4'd3, 1,0,0, 3,0));
      tbl.push_back(dk("ok_defused", 4'd4, 1,1,1, 4,0));
      tbl.push_back(mk("defused_hold",   0,0,0,4'd0,0,5'd12, 1,1,0,1,0,4,0));
      tbl.push_back(mk("defused_dv_ign", 0,0,1,4'd5,0,5'd12, 1,1,0,1,0,4,0));
      tbl.push_back(mk("defused_blow_ign",0,0,0,4'd0,1,5'd0, 1,1,0,1,0,4,0));
      tbl.push_back(mk("rearm_defused",  0,1,0,4'd0,0,5'd12, 0,0,1,0,0,0,0));
      tbl.push_back(mk("running2",       0,0,0,4'd0,0,5'd20, 1,0,0,0,0,0,0));
      // Wrong codes up to lockout, then explosion while locked.
      tbl.push_back(dk("w1_d1", 4'd1, 1,0,0, 1,0));
      tbl.push_back(mk("arm_in_running", 0,1,0,4'd0,0,5'd20, 1,0,0,0,0,1,0));
      tbl.push_back(mk("counter_zero",   0,0,0,4'd0,0,5'd0,  1,0,0,0,0,1,0));
      tbl.push_back(dk("w1_d2", 4'd2, 1,0,0, 2,0));
      tbl.push_back(dk("w1_d3", 4'd3, 1,0,0, 3,0));
      tbl.push_back(dk("w1_d4_wrong", 4'd5, 1,0,0, 0,1));

      foreach (tbl[i]) step(tbl[i]);

      attempt("w2", 4'd5, 1, 2);
      attempt("w3", 4'd5, 2, 3);
      step(dk("locked_dv_ign", 4'd1, 1,0,0, 0,3));
      step(mk("locked_arm_ign",   0,1,0,4'd0,0,5'd9, 1,0,0,0,0,0,3));
      step(mk("locked_cnt_zero",  0,0,0,4'd0,0,5'd0, 1,0,0,0,0,0,3));
      step(mk("locked_blow",      0,0,0,4'd0,1,5'd0, 0,0,0,0,1,0,3));
      step(mk("exploded_hold",    0,0,1,4'd1,0,5'd0, 0,0,0,0,1,0,3));
      step(mk("rearm_exploded",   0,1,0,4'd0,0,5'd9, 0,0,1,0,0,0,0));
      step(mk("running3",         0,0,0,4'd0,0,5'd9, 1,0,0,0,0,0,0));

      // Non-BCD digits and unqualified digits do not count.
      step(dk("bcd_d1", 4'd1, 1,0,0, 1,0));
      step(dk("bcd_A_ign", 4'hA, 1,0,0, 1,0));
      step(dk("bcd_F_ign", 4'hF, 1,0,0, 1,0));
      step(mk("no_dv_ign",        0,0,0,4'd9,0,5'd9, 1,0,0,0,0,1,0));
      step(dk("bcd_d2", 4'd2, 1,0,0, 2,0));
      step(dk("bcd_d3", 4'd3, 1,0,0, 3,0));
      step(dk("bcd_defused", 4'd4, 1,1,1, 4,0));
      step(mk("rearm4",           0,1,0,4'd0,0,5'd9, 0,0,1,0,0,0,0));
      step(mk("running4",         0,0,0,4'd0,0,5'd9, 1,0,0,0,0,0,0));

      // Explosion beats a same-cycle correct final digit.
      step(dk("race_d1", 4'd1, 1,0,0, 1,0));
      step(dk("race_d2", 4'd2, 1,0,0, 2,0));
      step(dk("race_d3", 4'd3, 1,0,0, 3,0));
      step(mk("race_blow_d4",     0,0,1,4'd4,1,5'd1, 0,0,0,0,1,3,0));
      step(mk("race_hold",        0,0,0,4'd0,0,5'd0, 0,0,0,0,1,3,0));
      step(mk("rearm5",           0,1,0,4'd0,0,5'd9, 0,0,1,0,0,0,0));
      step(mk("running5",         0,0,0,4'd0,0,5'd9, 1,0,0,0,0,0,0));

      // Reset mid-run overrides arm, digit and blow-up in the same cycle.
      step(dk("mid_d1", 4'd1, 1,0,0, 1,0));
      step(dk("mid_d2", 4'd2, 1,0,0, 2,0));
      step(mk("mid_reset",        1,1,1,4'd3,1,5'd9, 0,0,0,0,0,0,0));
      step(mk("post_reset_idle",  0,0,0,4'd0,0,5'd9, 0,0,0,0,0,0,0));
      step(mk("post_reset_arm",   0,1,0,4'd0,0,5'd9, 0,0,1,0,0,0,0));
      step(mk("clear_dv_ign",     0,0,1,4'd1,0,5'd9, 1,0,0,0,0,0,0));
      step(dk("post_reset_d1", 4'd1, 1,0,0, 1,0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bomb_defuse_controller.md
BOMB_DEFUSE_CONTROLLER -- requirements
Module: bomb_defuse_controller

Interface
REQ-001 Parameter CODE, default 16'h1234, SHALL be the secret code as 4 BCD digits, first-entered digit in [15:12].
REQ-002 Parameter MAX_ATTEMPTS, default 3, SHALL set the wrong-code count (1..3) that locks code entry.
REQ-003 Clock  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Arm  input  1  SHALL be a one-cycle request to (re)start a bomb run.
REQ-006 Digit_Valid  input  1  SHALL qualify Digit for one cycle.
REQ-007 Digit  input  4  SHALL be the entered BCD digit.
REQ-008 Counter_In  input  5  SHALL be the bomb countdown value.
REQ-009 Blow_Up_In  input  1  SHALL be the bomb explosion flag.
REQ-010 Start  output  1  SHALL be the level start command to the bomb.
REQ-011 Stop  output  1  SHALL be the level stop command to the bomb.
REQ-012 Bomb_Reset  output  1  SHALL be the one-cycle reset pulse to the bomb.
REQ-013 Defused / Exploded  output  1 each  SHALL be the terminal status flags.
REQ-014 Digits_Entered  output  3  SHALL be the buffered digit count (0..4).
REQ-015 Wrong_Attempts  output  2  SHALL be the failed-code count.

Function
REQ-016 All outputs SHALL be registered; each changes in the cycle after the edge that decides it.
REQ-017 The FSM SHALL have states IDLE, CLEAR, RUNNING, LOCKED, DEFUSED, EXPLODED.
REQ-018 IDLE: Start=0, Stop=0, Bomb_Reset=0; Arm -> CLEAR.
REQ-019 CLEAR SHALL last exactly one cycle with Bomb_Reset=1, clear the digit buffer and Wrong_Attempts, then enter RUNNING.
REQ-020 RUNNING SHALL hold Start=1 and Stop=0.
REQ-021 In RUNNING, a Digit_Valid with Digit <= 9 SHALL be appended; Digit > 9 SHALL be ignored with no count change.
REQ-022 On the edge accepting the 4th digit, a match with CODE -> DEFUSED; a mismatch SHALL clear the buffer and increment Wrong_Attempts.
REQ-023 A mismatch bringing Wrong_Attempts to MAX_ATTEMPTS -> LOCKED; LOCKED SHALL keep Start=1, Stop=0 and ignore digits.
REQ-024 DEFUSED SHALL assert Stop=1, Start=1 and Defused=1, holding them until Arm or Reset.
REQ-025 Blow_Up_In=1 in RUNNING or LOCKED -> EXPLODED (Exploded=1, Start=0, Stop=0); this SHALL take priority over a same-cycle code match.
REQ-026 Counter_In == 0 with Blow_Up_In=0 SHALL NOT change state.
REQ-027 Arm in DEFUSED or EXPLODED SHALL go to CLEAR and clear Defused/Exploded; Arm in RUNNING or LOCKED SHALL be ignored.
REQ-028 Digit_Valid outside RUNNING SHALL be ignored.

Reset
REQ-029 Reset SHALL force IDLE and drive Start, Stop, Bomb_Reset, Defused and Exploded to 0, and Digits_Entered and Wrong_Attempts to 0.
REQ-030 Reset SHALL override Arm, Digit_Valid and Blow_Up_In in the same cycle, including mid-run.

Structure
REQ-031 Package bomb_pkg SHALL hold the state enum, CODE_DIGITS=4 and the MAX_ATTEMPTS default.
REQ-032 Sub-module code_entry_buffer SHALL implement the 16-bit digit shift register, digit count, clear and compare-equal output.

Verification
REQ-033 Reset; Arm; digits 1,2,3,4 -> Bomb_Reset pulses once, Start=1, then Stop=1 and Defused=1 one cycle after the 4th digit.
REQ-034 Arm; enter 1,2,3,5 three times -> Wrong_Attempts steps 1,2,3; state LOCKED; later digits ignored; Blow_Up_In=1 -> Exploded=1, Start=0.
REQ-035 Arm; digits 1,A,2,3,4 -> A ignored; Defused=1.
REQ-036 RUNNING with 3 digits buffered; 4th digit 4 and Blow_Up_In=1 in the same cycle -> Exploded=1, Defused=0.
REQ-037 Reset asserted mid-RUNNING with 2 digits buffered -> next cycle all outputs are 0; Arm restarts cleanly with Digits_Entered=0.
